mem_arbiter: RTL and testbench
==============================

MEM_ARBITER -- requirements
Module: mem_arbiter

Interface
REQ-001 SHALL have parameter WAIT_CYCLES, default 1, number of ACCESS cycles per transfer (legal 1..15).
REQ-002 SHALL have parameter ADDR_W, default 16, memory address width.
REQ-003 SHALL have port clk  input  1  single clock; all state changes on rising edge.
REQ-004 SHALL have port rst  input  1  reset, synchronous, active-high.
REQ-005 SHALL have port req  input  2  request per requester (bit 0 = control unit, bit 1 = loader).
REQ-006 SHALL have port we  input  2  per-requester write enable (1 = write, 0 = read).
REQ-007 SHALL have ports addr0/addr1  input  ADDR_W  per-requester address.
REQ-008 SHALL have ports wdata0/wdata1  input  8  per-requester write data.
REQ-009 SHALL have port gnt  output  2  one-hot owner of the memory, held from SETUP through DONE.
REQ-010 SHALL have port ack  output  2  one-cycle completion pulse to the granted requester.
REQ-011 SHALL have port rdata  output  8  captured read data, valid in the ack cycle and held until the next read completes.
REQ-012 SHALL have ports mem_ce, mem_r, mem_w, mem_oe  output  1 each  memory strobes.
REQ-013 SHALL have ports addr_bus  output  ADDR_W; mem_wdata  output  8; mem_rdata  input  8.

Function
REQ-014 SHALL implement FSM states IDLE, SETUP, ACCESS, DONE.
REQ-015 IDLE: if any req bit is high, SHALL latch the winner's id, we, addr and wdata, and go to SETUP; otherwise SHALL stay in IDLE.
REQ-016 SETUP: SHALL assert mem_ce, drive addr_bus/mem_wdata from the latched values, with mem_r/mem_w/mem_oe low; SHALL go to ACCESS next cycle.
REQ-017 ACCESS: SHALL keep mem_ce; for a read SHALL assert mem_r and mem_oe; for a write SHALL assert mem_w; SHALL stay WAIT_CYCLES cycles using a 4-bit down-counter.
REQ-018 On the last ACCESS cycle of a read, SHALL register mem_rdata into rdata.
REQ-019 DONE: SHALL pulse ack[id] for exactly one cycle with all strobes low, then return to IDLE.
REQ-020 Transfer latency, req sampled to ack, SHALL be WAIT_CYCLES+2 cycles after the IDLE sampling edge.
REQ-021 Requester inputs SHALL be latched only in IDLE; later changes to them or to req SHALL not affect the transfer in flight.
REQ-022 A req still high in the IDLE cycle after DONE SHALL start a new transfer (back-to-back allowed, one idle cycle between transfers).
REQ-023 Dropping req mid-transfer SHALL NOT abort it; the ack is still issued.
REQ-024 gnt SHALL be zero in IDLE; ack and gnt SHALL never have more than one bit set.
REQ-025 Simultaneous req = 2'b11: arbitration SHALL follow REQ-030/031.

Reset
REQ-026 rst high at a clock edge SHALL force IDLE, counter 0, gnt 0, ack 0, rdata 8'h00, all strobes 0, addr_bus 0, mem_wdata 0, and the last-owner pointer to 1 (requester 0 favoured).
REQ-027 Reset during SETUP/ACCESS/DONE SHALL abandon the transfer with no ack; the requester SHALL re-request.
REQ-028 req SHALL be ignored in any cycle where rst is high.

Configuration
REQ-029 Macro MEM_ARB_ROUND_ROBIN_EN SHALL select the arbitration policy.
REQ-030 With MEM_ARB_ROUND_ROBIN_EN defined: on 2'b11, SHALL grant the requester that was not last granted; the pointer SHALL update on every grant.
REQ-031 Without it: on 2'b11 SHALL always grant requester 0; the pointer logic SHALL be absent.

Structure
REQ-032 Shared package scpu_pkg SHALL hold the FSM state enum (arb_state_t), requester id constants REQ_CU=0 and REQ_LDR=1, and the default WAIT_CYCLES.
REQ-033 Sub-module mem_arb_pick SHALL be the combinational winner selection (req, pointer -> one-hot grant); all else SHALL be in mem_arbiter.

Verification
REQ-034 Reset, then idle: all outputs zero, FSM IDLE for 5 cycles.
REQ-035 req=01, we=0, addr0=16'h0010, mem_rdata=8'hA5, WAIT_CYCLES=1 -> gnt=01 for 3 cycles, mem_r/mem_oe high 1 cycle, ack[0] 3 cycles after sampling, rdata=8'hA5.
REQ-036 req=10, we=10, addr1=16'h1234, wdata1=8'h3C -> mem_w high 1 cycle with addr_bus=16'h1234 and mem_wdata=8'h3C, then ack[1].
REQ-037 req=11 held for 4 transfers: round-robin build grants 0,1,0,1; fixed-priority build grants 0,0,0,0.
REQ-038 WAIT_CYCLES=3, rst asserted in the 2nd ACCESS cycle -> next cycle IDLE, strobes low, no ack, rdata unchanged from reset value.
REQ-039 req0 dropped in SETUP and addr0 changed -> transfer completes to the original address and ack[0] still pulses.

Source files
------------

// File: rtl/scpu_pkg.sv
// Shared types and constants for the memory arbiter: FSM state encoding,
// requester ids and the default number of ACCESS cycles per transfer.
package scpu_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    SETUP  = 2'd1,
    ACCESS = 2'd2,
    DONE   = 2'd3
  } arb_state_t;

  localparam logic REQ_CU  = 1'b0;
  localparam logic REQ_LDR = 1'b1;

  localparam int DEFAULT_WAIT_CYCLES = 1;

endpackage

// File: rtl/mem_arb_pick.sv
// Combinational winner selection: turns the request vector and the id of the
// last granted requester into a one-hot grant. On a tie the other side wins.
module mem_arb_pick (
  input  logic [1:0] i_req,
  input  logic       i_last,
  output logic [1:0] o_gnt
);

  always_comb begin
    o_gnt = 2'b00;
    case (i_req)
      2'b01:   o_gnt = 2'b01;
      2'b10:   o_gnt = 2'b10;
      2'b11:   o_gnt = i_last ? 2'b01 : 2'b10;
      default: o_gnt = 2'b00;
    endcase
  end

endmodule

// File: rtl/mem_arbiter.sv
// Two-requester memory arbiter running IDLE/SETUP/ACCESS/DONE transfers.
// Define MEM_ARB_ROUND_ROBIN_EN for round-robin ties; otherwise requester 0 wins.
module mem_arbiter
  import scpu_pkg::*;
#(
  parameter int WAIT_CYCLES = DEFAULT_WAIT_CYCLES,
  parameter int ADDR_W      = 16
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [1:0]        req,
  input  logic [1:0]        we,
  input  logic [ADDR_W-1:0] addr0,
  input  logic [ADDR_W-1:0] addr1,
  input  logic [7:0]        wdata0,
  input  logic [7:0]        wdata1,
  output logic [1:0]        gnt,
  output logic [1:0]        ack,
  output logic [7:0]        rdata,
  output logic              mem_ce,
  output logic              mem_r,
  output logic              mem_w,
  output logic              mem_oe,
  output logic [ADDR_W-1:0] addr_bus,
  output logic [7:0]        mem_wdata,
  input  logic [7:0]        mem_rdata
);

  localparam logic [3:0] CNT_LOAD = 4'(WAIT_CYCLES - 1);

  arb_state_t        r_state;
  arb_state_t        w_next;
  logic [3:0]        r_cnt;
  logic              r_id;
  logic              r_we;
  logic [ADDR_W-1:0] r_addr;
  logic [7:0]        r_wdata;
  logic [7:0]        r_rdata;
  logic [1:0]        w_pick;
  logic [1:0]        w_owner;
  logic              w_ptr;
  logic              w_start;

  assign w_start = (r_state == IDLE) && (req != 2'b00);
  assign w_owner = r_id ? 2'b10 : 2'b01;
  assign rdata   = r_rdata;

`ifdef MEM_ARB_ROUND_ROBIN_EN
  logic r_last;

  // Remembers who won the most recent grant so a tie goes to the other side.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_last <= 1'b1;
    end else if (w_start) begin
      r_last <= w_pick[1];
    end
  end

  assign w_ptr = r_last;
`else
  assign w_ptr = 1'b1;
`endif

  mem_arb_pick u_pick (
    .i_req  (req),
    .i_last (w_ptr),
    .o_gnt  (w_pick)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= IDLE;
    end else begin
      r_state <= w_next;
    end
  end

  always_comb begin
    w_next    = r_state;
    gnt       = 2'b00;
    ack       = 2'b00;
    mem_ce    = 1'b0;
    mem_r     = 1'b0;
    mem_w     = 1'b0;
    mem_oe    = 1'b0;
    addr_bus  = '0;
    mem_wdata = 8'h00;
    case (r_state)
      IDLE: begin
        if (req != 2'b00) w_next = SETUP;
      end
      SETUP: begin
        gnt       = w_owner;
        mem_ce    = 1'b1;
        addr_bus  = r_addr;
        mem_wdata = r_wdata;
        w_next    = ACCESS;
      end
      ACCESS: begin
        gnt       = w_owner;
        mem_ce    = 1'b1;
        mem_r     = ~r_we;
        mem_oe    = ~r_we;
        mem_w     = r_we;
        addr_bus  = r_addr;
        mem_wdata = r_wdata;
        if (r_cnt == 4'd0) w_next = DONE;
      end
      DONE: begin
        gnt    = w_owner;
        ack    = w_owner;
        w_next = IDLE;
      end
      default: w_next = IDLE;
    endcase
  end

  // Requester inputs are frozen at the IDLE edge; nothing after that can disturb the transfer.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_cnt   <= 4'd0;
      r_id    <= REQ_CU;
      r_we    <= 1'b0;
      r_addr  <= '0;
      r_wdata <= 8'h00;
      r_rdata <= 8'h00;
    end else begin
      case (r_state)
        IDLE: begin
          if (w_start) begin
            r_id    <= w_pick[1] ? REQ_LDR : REQ_CU;
            r_we    <= w_pick[1] ? we[1] : we[0];
            r_addr  <= w_pick[1] ? addr1 : addr0;
            r_wdata <= w_pick[1] ? wdata1 : wdata0;
          end
        end
        SETUP: r_cnt <= CNT_LOAD;
        ACCESS: begin
          if (r_cnt != 4'd0) begin
            r_cnt <= r_cnt - 4'd1;
          end else if (!r_we) begin
            r_rdata <= mem_rdata;
          end
        end
        default: r_cnt <= 4'd0;
      endcase
    end
  end

endmodule

// File: tb/tb_mem_arbiter.sv
// Self-checking bench for mem_arbiter: two instances (1 and 3 ACCESS cycles)
// share one stimulus stream and are compared every cycle to a transfer-level model.
module tb_mem_arbiter;

  logic        clk = 1'b0;
  logic        tbRst;
  logic [1:0]  tbReq;
  logic [1:0]  tbWe;
  logic [15:0] tbAddr0, tbAddr1;
  logic [7:0]  tbWdata0, tbWdata1;
  logic [7:0]  tbMemRdata;

  logic [1:0]  gntA, ackA, gntB, ackB;
  logic [7:0]  rdataA, rdataB, wdA, wdB;
  logic        ceA, rA, wA, oeA, ceB, rB, wB, oeB;
  logic [15:0] abA, abB;

  int checks   = 0;
  int failures = 0;
  int ackIds[$];

  // Model state per instance: index 0 = one ACCESS cycle, index 1 = three.
  int          mW[2] = '{1, 3};
  bit          mBusy[2];
  int          mK[2];
  int          mId[2];
  logic        mWe[2];
  logic [15:0] mAddr[2];
  logic [7:0]  mWd[2];
  logic [7:0]  mRd[2];
  int          mLast[2];
  bit          roundRobin;

  always #5 clk = ~clk;

  mem_arbiter #(.WAIT_CYCLES(1), .ADDR_W(16)) dutA (
    .clk(clk), .rst(tbRst), .req(tbReq), .we(tbWe),
    .addr0(tbAddr0), .addr1(tbAddr1), .wdata0(tbWdata0), .wdata1(tbWdata1),
    .gnt(gntA), .ack(ackA), .rdata(rdataA),
    .mem_ce(ceA), .mem_r(rA), .mem_w(wA), .mem_oe(oeA),
    .addr_bus(abA), .mem_wdata(wdA), .mem_rdata(tbMemRdata)
  );

  mem_arbiter #(.WAIT_CYCLES(3), .ADDR_W(16)) dutB (
    .clk(clk), .rst(tbRst), .req(tbReq), .we(tbWe),
    .addr0(tbAddr0), .addr1(tbAddr1), .wdata0(tbWdata0), .wdata1(tbWdata1),
    .gnt(gntB), .ack(ackB), .rdata(rdataB),
    .mem_ce(ceB), .mem_r(rB), .mem_w(wB), .mem_oe(oeB),
    .addr_bus(abB), .mem_wdata(wdB), .mem_rdata(tbMemRdata)
  );

  task automatic checkOutput(input string tag, input logic [31:0] observed,
                             input logic [31:0] expected);
    checks++;
    if (observed !== expected) begin
      failures++;
      $display("[TB] FAIL %s observed=%h expected=%h", tag, observed, expected);
    end
  endtask

  function automatic int pickWinner(input logic [1:0] r, input int last);
    if (r == 2'b01) return 0;
    if (r == 2'b10) return 1;
    if (roundRobin) return (last == 0) ? 1 : 0;
    return 0;
  endfunction

  // One clock edge of the transfer-level model: a transfer occupies cycles
  // 1 (setup), 2..W+1 (access), W+2 (done), and read data lands at the end of cycle W+1.
  task automatic modelStep(input int i);
    if (tbRst) begin
      mBusy[i] = 0;
      mK[i]    = 0;
      mRd[i]   = 8'h00;
      mLast[i] = 1;
    end else if (mBusy[i]) begin
      if (mK[i] == mW[i] + 1 && !mWe[i]) mRd[i] = tbMemRdata;
      if (mK[i] == mW[i] + 2) mBusy[i] = 0;
      else mK[i]++;
    end else if (tbReq != 2'b00) begin
      mId[i]   = pickWinner(tbReq, mLast[i]);
      mWe[i]   = tbWe[mId[i]];
      mAddr[i] = (mId[i] == 1) ? tbAddr1 : tbAddr0;
      mWd[i]   = (mId[i] == 1) ? tbWdata1 : tbWdata0;
      mLast[i] = mId[i];
      mBusy[i] = 1;
      mK[i]    = 1;
    end
  endtask

  task automatic checkInstance(input int i, input logic [1:0] g, input logic [1:0] a,
                               input logic [7:0] rd, input logic ce, input logic r,
                               input logic w, input logic oe, input logic [15:0] ab,
                               input logic [7:0] wd);
    logic [1:0]  expG, expA;
    logic [3:0]  expS;
    logic [15:0] expAb;
    logic [7:0]  expWd;
    string       pfx;
    expG = 2'b00; expA = 2'b00; expS = 4'b0000; expAb = 16'h0000; expWd = 8'h00;
    if (mBusy[i]) begin
      expG = (mId[i] == 1) ? 2'b10 : 2'b01;
      if (mK[i] == mW[i] + 2) begin
        expA = expG;
      end else begin
        expAb = mAddr[i];
        expWd = mWd[i];
        expS[3] = 1'b1;
        if (mK[i] >= 2) begin
          if (mWe[i]) expS[1] = 1'b1;
          else begin
            expS[2] = 1'b1;
            expS[0] = 1'b1;
          end
        end
      end
    end
    pfx = $sformatf("W%0d", mW[i]);
    checkOutput({pfx, " gnt"}, 32'(g), 32'(expG));
    checkOutput({pfx, " ack"}, 32'(a), 32'(expA));
    checkOutput({pfx, " rdata"}, 32'(rd), 32'(mRd[i]));
    checkOutput({pfx, " ce/r/w/oe"}, 32'({ce, r, w, oe}), 32'(expS));
    checkOutput({pfx, " addr_bus"}, 32'(ab), 32'(expAb));
    checkOutput({pfx, " mem_wdata"}, 32'(wd), 32'(expWd));
  endtask

  // Drives one cycle of inputs, advances the model past the edge, checks at the falling edge.
  task automatic applyStimulus(input logic r, input logic [1:0] rq, input logic [1:0] w,
                               input logic [15:0] a0, input logic [15:0] a1,
                               input logic [7:0] d0, input logic [7:0] d1,
                               input logic [7:0] md);
    tbRst = r; tbReq = rq; tbWe = w; tbAddr0 = a0; tbAddr1 = a1;
    tbWdata0 = d0; tbWdata1 = d1; tbMemRdata = md;
    @(posedge clk);
    #1;
    modelStep(0);
    modelStep(1);
    @(negedge clk);
    checkInstance(0, gntA, ackA, rdataA, ceA, rA, wA, oeA, abA, wdA);
    checkInstance(1, gntB, ackB, rdataB, ceB, rB, wB, oeB, abB, wdB);
    if (ackA != 2'b00) ackIds.push_back(ackA[1] ? 1 : 0);
  endtask

  task automatic idleCycles(input int n);
    for (int c = 0; c < n; c++)
      applyStimulus(1'b0, 2'b00, 2'b00, 16'h0000, 16'h0000, 8'h00, 8'h00, 8'h00);
  endtask

  initial begin
    int expSeq[4];
`ifdef MEM_ARB_ROUND_ROBIN_EN
    roundRobin = 1'b1;
    expSeq = '{0, 1, 0, 1};
`else
    roundRobin = 1'b0;
    expSeq = '{0, 0, 0, 0};
`endif
    for (int i = 0; i < 2; i++) begin
      mBusy[i] = 0; mK[i] = 0; mId[i] = 0; mWe[i] = 1'b0;
      mAddr[i] = 16'h0; mWd[i] = 8'h0; mRd[i] = 8'h0; mLast[i] = 1;
    end

    $display("[TB] reset and idle");
    applyStimulus(1'b1, 2'b00, 2'b00, 16'h0, 16'h0, 8'h0, 8'h0, 8'h0);
    applyStimulus(1'b1, 2'b11, 2'b11, 16'hFFFF, 16'hFFFF, 8'hFF, 8'hFF, 8'hFF);
    idleCycles(5);

    $display("[TB] read from control unit");
    applyStimulus(1'b0, 2'b01, 2'b00, 16'h0010, 16'h0000, 8'h00, 8'h00, 8'hA5);
    for (int c = 0; c < 6; c++)
      applyStimulus(1'b0, 2'b00, 2'b00, 16'h0010, 16'h0000, 8'h00, 8'h00, 8'hA5);
    checkOutput("W1 read result", 32'(rdataA), 32'h0000_00A5);

    $display("[TB] write from loader");
    applyStimulus(1'b0, 2'b10, 2'b10, 16'h0000, 16'h1234, 8'h00, 8'h3C, 8'h00);
    idleCycles(6);

    $display("[TB] contention");
    ackIds.delete();
    for (int c = 0; c < 16; c++)
      applyStimulus(1'b0, 2'b11, 2'b00, 16'h0100, 16'h0200, 8'h11, 8'h22, 8'h5A);
    checkOutput("W1 contention ack count", 32'(ackIds.size()), 32'd4);
    for (int t = 0; t < 4; t++)
      checkOutput($sformatf("W1 contention grant %0d", t),
                  32'((t < ackIds.size()) ? ackIds[t] : 9), 32'(expSeq[t]));
    idleCycles(6);

    $display("[TB] request dropped and address changed in setup");
    ackIds.delete();
    applyStimulus(1'b0, 2'b01, 2'b00, 16'h0ABC, 16'h0000, 8'h00, 8'h00, 8'h77);
    applyStimulus(1'b0, 2'b00, 2'b01, 16'hFFFF, 16'h0000, 8'h99, 8'h00, 8'h77);
    idleCycles(6);
    checkOutput("W1 dropped req ack count", 32'(ackIds.size()), 32'd1);
    checkOutput("W1 dropped req ack id", 32'((ackIds.size() > 0) ? ackIds[0] : 9), 32'd0);

    $display("[TB] reset during access");
    applyStimulus(1'b1, 2'b00, 2'b00, 16'h0, 16'h0, 8'h0, 8'h0, 8'h0);
    applyStimulus(1'b0, 2'b01, 2'b00, 16'h0040, 16'h0000, 8'h00, 8'h00, 8'h5A);
    applyStimulus(1'b0, 2'b00, 2'b00, 16'h0040, 16'h0000, 8'h00, 8'h00, 8'h5A);
    applyStimulus(1'b0, 2'b00, 2'b00, 16'h0040, 16'h0000, 8'h00, 8'h00, 8'h5A);
    applyStimulus(1'b1, 2'b01, 2'b00, 16'h0040, 16'h0000, 8'h00, 8'h00, 8'h5A);
    checkOutput("W3 rdata after abort", 32'(rdataB), 32'd0);
    checkOutput("W3 strobes after abort", 32'({ceB, rB, wB, oeB}), 32'd0);
    idleCycles(6);

    $display("[TB] randomized traffic");
    for (int c = 0; c < 400; c++)
      applyStimulus(($urandom_range(0, 49) == 0), 2'($urandom), 2'($urandom),
                    16'($urandom), 16'($urandom), 8'($urandom), 8'($urandom),
                    8'($urandom));

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
